// File: rtl/pair_acc_pkg.sv
// Shared constants and types for the even/odd address-pair counter and its accumulator.
package pair_acc_pkg;

   localparam int ADDR_W     = 14;
   localparam int DATA_W     = 8;
   localparam int ACC_W      = 20;
   localparam int CNT_W      = 10;
   localparam int START_ADDR = 6144;
   localparam int END_ADDR   = 7166;
   localparam int N_PAIRS    = (END_ADDR - START_ADDR) / 2 + 1;

   // Window bounds as address-width vectors, plus the counter's terminal hold value.
   localparam logic [ADDR_W-1:0] WIN_LO    = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] WIN_HI    = ADDR_W'(END_ADDR);
   localparam logic [ADDR_W-1:0] TERM_ADDR = ADDR_W'(END_ADDR + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/pair_window_detect.sv
// Stage 1: samples Q_a and flags fresh, well-formed, in-window pairs or malformed ones.
module pair_window_detect #(
   parameter int ADDR_W     = 14,
   parameter int START_ADDR = 6144,
   parameter int END_ADDR   = 7166
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] q_a,
   input  logic [ADDR_W-1:0] q_b,
   output logic              new_pair_det,
   output logic              new_pair,
   output logic              err_pulse,
   output logic [ADDR_W-1:0] qa_reg
);
   import pair_acc_pkg::*;

   localparam logic [ADDR_W-1:0] LO = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] HI = ADDR_W'(END_ADDR);

   logic [ADDR_W-1:0] qa_q, qa_d;
   logic              seen_q, seen_d;
   logic              new_pair_q, new_pair_d;
   logic              err_q, err_d;
   logic              in_win;
   logic              pair_ok;
   logic              is_new;

   always_comb begin
      in_win     = (q_a[0] == 1'b0) && (q_a >= LO) && (q_a <= HI);
      pair_ok    = (q_b == q_a + ADDR_W'(1));
      // A held address only counts on its first cycle; seen_q covers the first sample after reset.
      is_new     = !seen_q || (q_a != qa_q);
      new_pair_d = in_win && pair_ok && is_new;
      err_d      = in_win && !pair_ok;
      qa_d       = q_a;
      seen_d     = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qa_q       <= '0;
         seen_q     <= 1'b0;
         new_pair_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         qa_q       <= qa_d;
         seen_q     <= seen_d;
         new_pair_q <= new_pair_d;
         err_q      <= err_d;
      end
   end

   assign new_pair_det = new_pair_d;
   assign new_pair     = new_pair_q;
   assign err_pulse    = err_q;
   assign qa_reg       = qa_q;

endmodule

// File: rtl/pair_accumulator.sv
// Accumulates ROM pair sums over a fixed address window: total, maximum with address, count, error.
module pair_accumulator #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 8,
   parameter int ACC_W      = 20,
   parameter int START_ADDR = 6144,
   parameter int END_ADDR   = 7166,
   parameter int N_PAIRS    = (END_ADDR - START_ADDR) / 2 + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Q_a,
   input  logic [ADDR_W-1:0] Q_b,
   input  logic [DATA_W-1:0] rom_q_a,
   input  logic [DATA_W-1:0] rom_q_b,
   output logic [ACC_W-1:0]  sum,
   output logic [DATA_W:0]   max_sum,
   output logic [ADDR_W-1:0] max_addr,
   output logic [9:0]        pair_cnt,
   output logic              busy,
   output logic              done,
   output logic              pair_err
);
   import pair_acc_pkg::*;

   logic              new_pair_det;
   logic              new_pair;
   logic              err_pulse;
   logic [ADDR_W-1:0] qa_reg;

   acc_state_t        state_q, state_d;
   logic [ACC_W-1:0]  sum_q, sum_d;
   logic [DATA_W:0]   max_q, max_d;
   logic [ADDR_W-1:0] max_addr_q, max_addr_d;
   logic [9:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DATA_W:0]   psum;
   logic              accept;

   pair_window_detect #(
      .ADDR_W     (ADDR_W),
      .START_ADDR (START_ADDR),
      .END_ADDR   (END_ADDR)
   ) u_detect (
      .clk          (clk),
      .reset        (reset),
      .q_a          (Q_a),
      .q_b          (Q_b),
      .new_pair_det (new_pair_det),
      .new_pair     (new_pair),
      .err_pulse    (err_pulse),
      .qa_reg       (qa_reg)
   );

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      max_d      = max_q;
      max_addr_d = max_addr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      psum       = {1'b0, rom_q_a} + {1'b0, rom_q_b};
      // Stage-1 flags lead the FSM by one edge, so a registered pair always lands in ACCUM or DONE.
      accept     = new_pair && (state_q == ACCUM);

      if (accept) begin
         sum_d = sum_q + ACC_W'(psum);
         cnt_d = cnt_q + 10'd1;
         if (psum > max_q) begin
            max_d      = psum;
            max_addr_d = qa_reg;
         end
      end

      if (err_pulse && (state_q != DONE)) begin
         err_d = 1'b1;
      end

      case (state_q)
         IDLE:    if (new_pair_det) state_d = ACCUM;
         ACCUM:   if (accept && (cnt_q == 10'(N_PAIRS - 1))) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         sum_q      <= '0;
         max_q      <= '0;
         max_addr_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         max_q      <= max_d;
         max_addr_q <= max_addr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign sum      = sum_q;
   assign max_sum  = max_q;
   assign max_addr = max_addr_q;
   assign pair_cnt = cnt_q;
   assign busy     = (state_q == ACCUM);
   assign done     = (state_q == DONE);
   assign pair_err = err_q;

endmodule

// File: tb/tb_pair_accumulator.sv
// Directed bench for pair_accumulator: models the pair counter and a registered ROM.
module tb_pair_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] Q_a;
   logic [13:0] Q_b;
   logic [7:0]  rom_q_a;
   logic [7:0]  rom_q_b;
   logic [19:0] sum;
   logic [8:0]  max_sum;
   logic [13:0] max_addr;
   logic [9:0]  pair_cnt;
   logic        busy;
   logic        done;
   logic        pair_err;

   int n_cmp     = 0;
   int n_mis     = 0;
   int data_mode = 0;

   always #5 clk = ~clk;

   pair_accumulator dut (
      .clk      (clk),
      .reset    (reset),
      .Q_a      (Q_a),
      .Q_b      (Q_b),
      .rom_q_a  (rom_q_a),
      .rom_q_b  (rom_q_b),
      .sum      (sum),
      .max_sum  (max_sum),
      .max_addr (max_addr),
      .pair_cnt (pair_cnt),
      .busy     (busy),
      .done     (done),
      .pair_err (pair_err)
   );

   function automatic logic [7:0] rom_word(input logic [13:0] a);
      if (data_mode == 1) return 8'hFF;
      return a[7:0];
   endfunction

   // Registered ROM: the word for the address presented before an edge is valid after it.
   always @(posedge clk) begin
      rom_q_a <= rom_word(Q_a);
      rom_q_b <= rom_word(Q_b);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic check_outputs(input string tag, input int e_sum, input int e_max,
                                input int e_addr, input int e_cnt, input int e_busy,
                                input int e_done, input int e_err);
      check_val({tag, ".sum"},      32'(sum),      32'(e_sum));
      check_val({tag, ".max_sum"},  32'(max_sum),  32'(e_max));
      check_val({tag, ".max_addr"}, 32'(max_addr), 32'(e_addr));
      check_val({tag, ".pair_cnt"}, 32'(pair_cnt), 32'(e_cnt));
      check_val({tag, ".busy"},     32'(busy),     32'(e_busy));
      check_val({tag, ".done"},     32'(done),     32'(e_done));
      check_val({tag, ".pair_err"}, 32'(pair_err), 32'(e_err));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      Q_a   = 14'd0;
      Q_b   = 14'd0;
      repeat (2) @(negedge clk);
      check_outputs("rst", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
   endtask

   // Presents n consecutive pairs from 6144; optional stall (5 cycles total) and malformed pair.
   task automatic run_pairs(input int n, input logic [13:0] stall_at, input logic [13:0] bad_at);
      for (int i = 0; i < n; i++) begin
         logic [13:0] a;
         a = 14'(6144 + 2 * i);
         @(negedge clk);
         if (i == 1) check_val("lat.busy", 32'(busy), 32'd1);
         if (i == 2) check_val("lat.cnt", 32'(pair_cnt), 32'd1);
         Q_a = a;
         Q_b = (a == bad_at) ? a + 14'd3 : a + 14'd1;
         if (a == stall_at) repeat (4) @(negedge clk);
      end
      @(negedge clk);
      Q_a = 14'd7168;
      Q_b = 14'd7169;
   endtask

   initial begin
      reset = 1'b0;
      Q_a   = 14'd0;
      Q_b   = 14'd0;

      // Incrementing data, full window.
      data_mode = 0;
      do_reset();
      run_pairs(512, 14'd0, 14'd0);
      check_val("inc.pre.cnt", 32'(pair_cnt), 32'd511);
      check_val("inc.pre.done", 32'(done), 32'd0);
      @(negedge clk);
      check_outputs("inc", 130560, 509, 6398, 512, 0, 1, 0);

      // Terminal hold and a stray in-window pair after done change nothing.
      repeat (3) @(negedge clk);
      Q_a = 14'd6144;
      Q_b = 14'd6145;
      repeat (2) @(negedge clk);
      Q_a = 14'd7168;
      Q_b = 14'd7169;
      repeat (3) @(negedge clk);
      check_outputs("oow", 130560, 509, 6398, 512, 0, 1, 0);

      // Constant 0xFF data: every pair ties, first address wins.
      data_mode = 1;
      do_reset();
      run_pairs(512, 14'd0, 14'd0);
      @(negedge clk);
      check_outputs("const", 261120, 510, 6144, 512, 0, 1, 0);

      // Held address at 6200 counts once.
      data_mode = 0;
      do_reset();
      run_pairs(512, 14'd6200, 14'd0);
      check_val("hold.pre.cnt", 32'(pair_cnt), 32'd511);
      @(negedge clk);
      check_outputs("hold", 130560, 509, 6398, 512, 0, 1, 0);

      // Malformed pair at 6400 (psum would be 1) is dropped, window never completes.
      do_reset();
      run_pairs(512, 14'd0, 14'd6400);
      check_val("bad.pre.cnt", 32'(pair_cnt), 32'd510);
      repeat (4) @(negedge clk);
      check_outputs("bad", 130559, 509, 6398, 511, 1, 0, 1);

      // Asynchronous reset mid-window, then a full rerun.
      do_reset();
      run_pairs(100, 14'd0, 14'd0);
      @(posedge clk);
      #3;
      check_val("mid.cnt", 32'(pair_cnt), 32'd100);
      check_val("mid.sum", 32'(sum), 32'd19900);
      reset = 1'b0;
      #1;
      check_outputs("async", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      run_pairs(512, 14'd0, 14'd0);
      @(negedge clk);
      check_outputs("rerun", 130560, 509, 6398, 512, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
